// File: rtl/pair_source.sv
// Producer end of the dual dav/rfd handshake: a small FIFO of (x, y) pairs sent on two 8-bit channels.
// Optional end-to-end pulse-length checker enabled by defining PAIR_SOURCE_MAXCHECK_EN.
module pair_source #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clock,
    input  logic         reset_,
    input  logic         wr,
    input  logic [W-1:0] wdata_x,
    input  logic [W-1:0] wdata_y,
    output logic         full,
    output logic         empty,
    output logic         ovf,
    output logic [W-1:0] x,
    output logic [W-1:0] y,
    output logic         dav_x,
    output logic         dav_y,
    input  logic         rfd_x,
    input  logic         rfd_y,
`ifdef PAIR_SOURCE_MAXCHECK_EN
    input  logic         out,
    output logic         err,
`endif
    output logic [7:0]   sent
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = (AW)'(1);

    typedef enum logic [1:0] {S0, S1, S2} state_t;

    state_t state, state_next;

    logic [2*W-1:0] mem [DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [AW:0]    count, count_next;
    logic           full_q, empty_q, ovf_q;
    logic           push, pop;
    logic           load, done, dav_next;
    logic           dav_q;
    logic [W-1:0]   x_q, y_q;
    logic [7:0]     sent_q;

    // A full FIFO refuses the write even if a pop frees a slot in the same cycle.
    assign push = wr && !full_q;
    assign pop  = load;

    always_comb begin
        count_next = count;
        unique case ({push, pop})
            2'b10:   count_next = count + CNT_ONE;
            2'b01:   count_next = count - CNT_ONE;
            default: count_next = count;
        endcase
    end

    // NOTE: storage has no reset; clearing the pointers and count is what empties the FIFO.
    always_ff @(posedge clock) begin
        if (push)
            mem[wr_ptr] <= {wdata_x, wdata_y};
    end

    // NOTE: all state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge reset_) begin
        if (reset_) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)
                rd_ptr <= rd_ptr + PTR_ONE;
            count   <= count_next;
            full_q  <= (count_next == DEPTH_C);
            empty_q <= (count_next == '0);
            if (wr && full_q)
                ovf_q <= 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset_) begin
        if (reset_)
            state <= S0;
        else
            state <= state_next;
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        unique case (state)
            S0:      if (!empty_q && rfd_x && rfd_y) state_next = S1;
            S1:      state_next = S2;
            S2:      if (!rfd_x && !rfd_y) state_next = S0;
            default: state_next = S0;
        endcase
    end

    always_comb begin
        load     = (state == S0) && (state_next == S1);
        done     = (state == S2) && (state_next == S0);
        dav_next = (state_next != S2);
    end

    // x/y load one cycle before dav falls and hold until the next pop.
    always_ff @(posedge clock or posedge reset_) begin
        if (reset_) begin
            dav_q  <= 1'b1;
            x_q    <= '0;
            y_q    <= '0;
            sent_q <= '0;
        end else begin
            dav_q <= dav_next;
            if (load) begin
                x_q <= mem[rd_ptr][2*W-1:W];
                y_q <= mem[rd_ptr][W-1:0];
            end
            if (done)
                sent_q <= sent_q + 8'd1;
        end
    end

`ifdef PAIR_SOURCE_MAXCHECK_EN
    localparam int CW = W + 1;
    localparam logic [CW-1:0] CW_ONE = (CW)'(1);

    logic [CW-1:0] pulse_cnt;
    logic [CW-1:0] expected;
    logic [W-1:0]  max_xy;
    logic          out_q, armed, err_q;

    // A zero maximum means the consumer counts a full 2**W cycles.
    always_comb begin
        max_xy   = (x_q > y_q) ? x_q : y_q;
        expected = (max_xy == '0) ? {1'b1, {W{1'b0}}} : {1'b0, max_xy};
    end

    always_ff @(posedge clock or posedge reset_) begin
        if (reset_) begin
            pulse_cnt <= '0;
            out_q     <= 1'b0;
            armed     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            out_q <= out;
            if (done) begin
                pulse_cnt <= '0;
                armed     <= 1'b1;
            end else if (armed) begin
                if (out && !out_q)
                    pulse_cnt <= CW_ONE;
                else if (out && (pulse_cnt != '1))
                    pulse_cnt <= pulse_cnt + CW_ONE;
                if (!out && out_q && (pulse_cnt != expected))
                    err_q <= 1'b1;
            end
        end
    end

    assign err = err_q;
`endif

    assign full  = full_q;
    assign empty = empty_q;
    assign ovf   = ovf_q;
    assign x     = x_q;
    assign y     = y_q;
    assign dav_x = dav_q;
    assign dav_y = dav_q;
    assign sent  = sent_q;

endmodule

// File: tb/tb_pair_source.sv
// Directed bench for pair_source: reset, single pair, burst/overflow, skewed consumer, async reset.
// Checker tests run when PAIR_SOURCE_MAXCHECK_EN is defined.
module tb_pair_source;

    logic       clock = 1'b0;
    logic       reset_;
    logic       wr;
    logic [7:0] wdata_x, wdata_y;
    logic       full, empty, ovf;
    logic [7:0] x, y;
    logic       dav_x, dav_y;
    logic       rfd_x, rfd_y;
    logic [7:0] sent;
`ifdef PAIR_SOURCE_MAXCHECK_EN
    logic       out;
    logic       err;
`endif

    int checks = 0;
    int errors = 0;

    pair_source #(.DEPTH(4), .W(8)) dut (
        .clock   (clock),
        .reset_  (reset_),
        .wr      (wr),
        .wdata_x (wdata_x),
        .wdata_y (wdata_y),
        .full    (full),
        .empty   (empty),
        .ovf     (ovf),
        .x       (x),
        .y       (y),
        .dav_x   (dav_x),
        .dav_y   (dav_y),
        .rfd_x   (rfd_x),
        .rfd_y   (rfd_y),
`ifdef PAIR_SOURCE_MAXCHECK_EN
        .out     (out),
        .err     (err),
`endif
        .sent    (sent)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic write_pair(input logic [7:0] px, input logic [7:0] py);
        wr = 1'b1;
        wdata_x = px;
        wdata_y = py;
        tick();
        wr = 1'b0;
    endtask

    // Consumer: raise rfd, wait for dav low, verify pair and setup, drop rfd, wait for dav high.
    task automatic xfer(input string tag, input logic [7:0] ex, input logic [7:0] ey);
        logic [7:0] px, py;
        int n;
        rfd_x = 1'b1;
        rfd_y = 1'b1;
        px = x;
        py = y;
        n = 0;
        while (dav_x !== 1'b0 && n < 20) begin
            px = x;
            py = y;
            tick();
            n++;
        end
        check({tag, "_dav_low"}, {dav_x, dav_y}, 2'b00);
        check({tag, "_x"}, x, ex);
        check({tag, "_y"}, y, ey);
        check({tag, "_setup"}, {px, py}, {ex, ey});
        rfd_x = 1'b0;
        rfd_y = 1'b0;
        n = 0;
        while (dav_x !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_dav_high"}, {dav_x, dav_y}, 2'b11);
    endtask

    initial begin
        reset_ = 1'b1;
        wr = 1'b0;
        wdata_x = '0;
        wdata_y = '0;
        rfd_x = 1'b0;
        rfd_y = 1'b0;
`ifdef PAIR_SOURCE_MAXCHECK_EN
        out = 1'b0;
`endif
        tick();
        check("rst_dav", {dav_x, dav_y}, 2'b11);
        check("rst_xy", {x, y}, 16'h0000);
        check("rst_flags", {full, empty, ovf}, 3'b010);
        check("rst_sent", sent, 8'd0);
        @(negedge clock);
        reset_ = 1'b0;
        tick();

        // Single pair with explicit timing
        write_pair(8'd5, 8'd9);
        check("sp_empty0", empty, 1'b0);
        rfd_x = 1'b1;
        rfd_y = 1'b1;
        tick();
        check("sp_pop_xy", {x, y}, {8'd5, 8'd9});
        check("sp_pop_dav", dav_x, 1'b1);
        check("sp_pop_empty", empty, 1'b1);
        tick();
        check("sp_dav0", {dav_x, dav_y}, 2'b00);
        tick();
        tick();
        check("sp_hold_dav", dav_x, 1'b0);
        rfd_x = 1'b0;
        rfd_y = 1'b0;
        tick();
        check("sp_dav1", {dav_x, dav_y}, 2'b11);
        check("sp_sent", sent, 8'd1);
        check("sp_xy_kept", {x, y}, {8'd5, 8'd9});

        // Burst to full, then overflow while consumer stalls
        write_pair(8'd1, 8'd2);
        write_pair(8'd3, 8'd4);
        write_pair(8'd7, 8'd6);
        check("bu_not_full", full, 1'b0);
        write_pair(8'd0, 8'd255);
        check("bu_full", {full, empty}, 2'b10);
        check("bu_ovf0", ovf, 1'b0);
        write_pair(8'd8, 8'd8);
        check("ov_ovf", ovf, 1'b1);
        check("ov_full", full, 1'b1);
        tick();
        check("ov_sticky", ovf, 1'b1);

        xfer("bu0", 8'd1, 8'd2);
        check("bu_full_clr", full, 1'b0);
        xfer("bu1", 8'd3, 8'd4);
        xfer("bu2", 8'd7, 8'd6);
        xfer("bu3", 8'd0, 8'd255);
        check("bu_sent", sent, 8'd5);
        check("bu_empty", empty, 1'b1);
        tick();
        tick();
        check("bu_no_extra", {sent, dav_x, ovf}, {8'd5, 1'b1, 1'b1});

        // Skewed consumer
        write_pair(8'h11, 8'h22);
        rfd_x = 1'b1;
        rfd_y = 1'b0;
        tick();
        tick();
        tick();
        check("sk_wait_dav", dav_x, 1'b1);
        check("sk_wait_empty", empty, 1'b0);
        rfd_y = 1'b1;
        tick();
        tick();
        check("sk_dav0", {dav_x, dav_y}, 2'b00);
        check("sk_xy", {x, y}, 16'h1122);
        rfd_x = 1'b0;
        tick();
        tick();
        check("sk_hold_dav", dav_x, 1'b0);
        check("sk_hold_sent", sent, 8'd5);
        rfd_y = 1'b0;
        tick();
        check("sk_done_dav", {dav_x, dav_y}, 2'b11);
        check("sk_sent", sent, 8'd6);
        tick();
        check("sk_sent_once", sent, 8'd6);

        // Asynchronous reset while in wait-ack
        write_pair(8'h33, 8'h44);
        write_pair(8'h55, 8'h66);
        rfd_x = 1'b1;
        rfd_y = 1'b1;
        tick();
        tick();
        check("ar_in_s2", dav_x, 1'b0);
        #2;
        reset_ = 1'b1;
        #1;
        check("ar_dav", {dav_x, dav_y}, 2'b11);
        check("ar_sent", sent, 8'd0);
        check("ar_flags", {full, empty, ovf}, 3'b010);
        check("ar_xy", {x, y}, 16'h0000);
        @(negedge clock);
        reset_ = 1'b0;
        rfd_x = 1'b0;
        rfd_y = 1'b0;
        tick();
        write_pair(8'h5A, 8'hA5);
        xfer("ar_post", 8'h5A, 8'hA5);
        check("ar_post_sent", sent, 8'd1);
        check("ar_post_empty", empty, 1'b1);

`ifdef PAIR_SOURCE_MAXCHECK_EN
        write_pair(8'd3, 8'd200);
        xfer("mc_a", 8'd3, 8'd200);
        out = 1'b1;
        repeat (200) tick();
        out = 1'b0;
        tick();
        tick();
        check("mc_200_ok", err, 1'b0);

        write_pair(8'd10, 8'd4);
        xfer("mc_b", 8'd10, 8'd4);
        out = 1'b1;
        repeat (199) tick();
        out = 1'b0;
        tick();
        tick();
        check("mc_199_err", err, 1'b1);

        @(negedge clock);
        reset_ = 1'b1;
        @(negedge clock);
        reset_ = 1'b0;
        tick();
        check("mc_err_rst", err, 1'b0);
        write_pair(8'd0, 8'd0);
        xfer("mc_c", 8'd0, 8'd0);
        out = 1'b1;
        repeat (256) tick();
        out = 1'b0;
        tick();
        tick();
        check("mc_256_ok", err, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
